cpu_top_rv32i: RTL and testbench

//  Top of the single-cycle RV32I processor: an instruction ROM (u_ins_rom) plus a core (u_cpu_core)

---
 rtl/cpu_top_rv32i.sv | 238 +++++++++++++++++++++++
 tb/tb_cpu_top_rv32i.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_top_rv32i.sv
// ============================================================================
// Module      : cpu_top_rv32i
// Description : Single-cycle RV32I processor. Instruction ROM plus a core
//               holding the PC register, register file, decode/ALU and a
//               word-addressed data RAM. Only clock and reset are ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// Instruction ROM: combinational word read, contents loaded externally.
// ----------------------------------------------------------------------------
module ins_rom #(
    parameter int ROM_DEPTH = 4096
) (
    input  logic [31:0] addr_i,
    output logic [31:0] instr_o
);
    // Depth is assumed to be a power of two so the index wraps naturally.
    localparam int c_AW = $clog2(ROM_DEPTH);

    logic [31:0] rom_mem [0:ROM_DEPTH-1];
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{addr_i[31:c_AW+2], addr_i[1:0]};
    assign instr_o          = rom_mem[addr_i[2 +: c_AW]];
endmodule

// ----------------------------------------------------------------------------
// Program counter register.
// ----------------------------------------------------------------------------
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc2if_addr_o
);
    logic [31:0] pc_q;

    // PC advances every cycle; reset forces the restart address.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pc_q <= RESET_PC;
        else          pc_q <= pc_d_i;
    end

    assign pc2if_addr_o = pc_q;
endmodule

// ----------------------------------------------------------------------------
// Register file: 32 x 32, two asynchronous reads, one synchronous write.
// ----------------------------------------------------------------------------
module regs (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] x_regs [0:31];

    // Writes to x0 are dropped so it stays zero after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) x_regs[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            x_regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : x_regs[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : x_regs[raddr2_i];
endmodule

// ----------------------------------------------------------------------------
// Core: decode, execute, data RAM and next-PC selection.
// ----------------------------------------------------------------------------
module cpu_core #(
    parameter int          RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o
);
    localparam int         c_RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [31:0] pc, pc_d, pc_plus4, rs1_val, rs2_val, rf_wdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, ld_addr, st_addr;
    logic        rf_we, ram_we, br_taken, unused_addr_bits;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] ram_mem [0:RAM_DEPTH-1];

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b    = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u    = {instr_i[31:12], 12'd0};
    assign imm_j    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;
    assign ld_addr  = rs1_val + imm_i;
    assign st_addr  = rs1_val + imm_s;
    assign pc_o     = pc;

    // Word RAM ignores the byte offset and upper address bits.
    assign unused_addr_bits = ^{ld_addr[31:c_RAM_AW+2], ld_addr[1:0],
                                st_addr[31:c_RAM_AW+2], st_addr[1:0]};

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .pc_d_i(pc_d), .pc2if_addr_o(pc)
    );

    regs u_regs (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .we_i(rf_we), .waddr_i(instr_i[11:7]),
        .wdata_i(rf_wdata), .raddr1_i(instr_i[19:15]), .raddr2_i(instr_i[24:20]),
        .rdata1_o(rs1_val), .rdata2_o(rs2_val)
    );

    // Shared integer ALU; alt selects SUB / SRA.
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  alu = alt ? (a - b) : (a + b);
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'd0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    // Branch condition evaluation; reserved funct3 codes never branch.
    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Decode/execute; anything not recognised (including X words) is a NOP.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = 32'd0;
        ram_we   = 1'b0;
        pc_d     = pc_plus4;
        case (opcode)
            c_OP_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
            c_OP_AUIPC: begin rf_we = 1'b1; rf_wdata = pc + imm_u; end
            c_OP_JAL:   begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = pc + imm_j; end
            c_OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we    = 1'b1;
                    rf_wdata = pc_plus4;
                    pc_d     = ld_addr & ~32'd1;
                end
            end
            c_OP_BRANCH: if (br_taken) pc_d = pc + imm_b;
            c_OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    rf_we    = 1'b1;
                    rf_wdata = ram_mem[ld_addr[2 +: c_RAM_AW]];
                end
            end
            c_OP_STORE: ram_we = (funct3 == 3'b010);
            c_OP_IMM: begin
                if ((funct3 == 3'b001 && funct7 == 7'd0) ||
                    (funct3 == 3'b101 && (funct7 == 7'd0 || funct7 == 7'b0100000)) ||
                    (funct3 != 3'b001 && funct3 != 3'b101)) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu(funct3, (funct3 == 3'b101) && instr_i[30], rs1_val, imm_i);
                end
            end
            c_OP_REG: begin
                if (funct7 == 7'd0 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu(funct3, instr_i[30], rs1_val, rs2_val);
                end
            end
            default: ;
        endcase
    end

    // Data RAM write; deliberately not reset so contents survive a restart.
    always_ff @(posedge clk_i) begin
        if (ram_we) ram_mem[st_addr[2 +: c_RAM_AW]] <= rs2_val;
    end
endmodule

// ----------------------------------------------------------------------------
// Top level.
// ----------------------------------------------------------------------------
module cpu_top_rv32i #(
    parameter int          ROM_DEPTH = 4096,
    parameter int          RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rest
);
    logic [31:0] fetch_pc;
    logic [31:0] instr;

    ins_rom #(.ROM_DEPTH(ROM_DEPTH)) u_ins_rom (
        .addr_i(fetch_pc), .instr_o(instr)
    );

    cpu_core #(.RAM_DEPTH(RAM_DEPTH), .RESET_PC(RESET_PC)) u_cpu_core (
        .clk_i(clk), .rst_n_i(rest), .instr_i(instr), .pc_o(fetch_pc)
    );
endmodule

`default_nettype wire

// File: tb/tb_cpu_top_rv32i.sv
// ============================================================================
// Module      : tb_cpu_top_rv32i
// Description : Directed self-checking bench for cpu_top_rv32i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_top_rv32i;
    localparam logic [6:0] c_IMM = 7'b0010011, c_REG = 7'b0110011, c_LUI = 7'b0110111;
    localparam logic [6:0] c_AUIPC = 7'b0010111, c_JALR = 7'b1100111, c_LOAD = 7'b0000011;

    logic clk;
    logic rest;
    int   n_checks;
    int   n_fail;

    cpu_top_rv32i dut (.clk(clk), .rest(rest));

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, c_REG};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic put(input int addr, input logic [31:0] word);
        dut.u_ins_rom.rom_mem[addr / 4] = word;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_program();
        put(32'h00, enc_i(12'd5,   5'd0, 3'b000, 5'd1, c_IMM));      // addi x1,x0,5
        put(32'h04, enc_i(12'hFFE, 5'd1, 3'b000, 5'd3, c_IMM));      // addi x3,x1,-2
        put(32'h08, enc_r(7'h00, 5'd3, 5'd1, 3'b000, 5'd4));         // add  x4,x1,x3
        put(32'h0C, enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd5));         // sub  x5,x3,x1
        put(32'h10, enc_b(13'd8, 5'd1, 5'd1, 3'b000));               // beq  x1,x1,+8
        put(32'h14, enc_i(12'd1,   5'd0, 3'b000, 5'd9, c_IMM));      // addi x9,x0,1 (skipped)
        put(32'h18, enc_b(13'd8, 5'd1, 5'd1, 3'b001));               // bne  x1,x1,+8
        put(32'h1C, enc_b(13'd8, 5'd1, 5'd5, 3'b110));               // bltu x5,x1,+8
        put(32'h20, enc_j(21'd12, 5'd1));                            // jal  x1,+12
        put(32'h24, enc_b(13'd12, 5'd1, 5'd5, 3'b100));              // blt  x5,x1,+12
        put(32'h28, enc_i(12'd1,   5'd0, 3'b000, 5'd9, c_IMM));      // skipped
        put(32'h2C, enc_i(12'd1,   5'd1, 3'b000, 5'd0, c_JALR));     // jalr x0,1(x1)
        put(32'h30, enc_i(12'd7,   5'd0, 3'b000, 5'd0, c_IMM));      // addi x0,x0,7
        put(32'h34, enc_u(20'h12345, 5'd6, c_LUI));                  // lui  x6,0x12345
        put(32'h38, enc_i(12'h401, 5'd5, 3'b101, 5'd7, c_IMM));      // srai x7,x5,1
        put(32'h3C, enc_s(12'd4, 5'd4, 5'd0));                       // sw   x4,4(x0)
        put(32'h40, enc_i(12'd4,   5'd0, 3'b010, 5'd6, c_LOAD));     // lw   x6,4(x0)
        put(32'h44, enc_u(20'h00001, 5'd10, c_AUIPC));               // auipc x10,1
        put(32'h48, enc_r(7'h00, 5'd3, 5'd4, 3'b001, 5'd11));        // sll  x11,x4,x3
        put(32'h4C, enc_r(7'h00, 5'd3, 5'd5, 3'b101, 5'd12));        // srl  x12,x5,x3
        put(32'h50, enc_r(7'h20, 5'd3, 5'd5, 3'b101, 5'd13));        // sra  x13,x5,x3
        put(32'h54, enc_r(7'h00, 5'd3, 5'd5, 3'b010, 5'd14));        // slt  x14,x5,x3
        put(32'h58, enc_r(7'h00, 5'd3, 5'd5, 3'b011, 5'd15));        // sltu x15,x5,x3
        put(32'h5C, 32'h0000_0073);                                  // ecall (NOP)
        put(32'h60, enc_b(13'd8, 5'd3, 5'd5, 3'b111));               // bgeu x5,x3,+8
        put(32'h64, enc_i(12'd1,   5'd0, 3'b000, 5'd9, c_IMM));      // skipped
        put(32'h68, enc_i(12'hFFF, 5'd3, 3'b011, 5'd16, c_IMM));     // sltiu x16,x3,-1
        put(32'h6C, enc_i(12'hFFF, 5'd5, 3'b100, 5'd17, c_IMM));     // xori x17,x5,-1
        put(32'h70, enc_i(12'd4,   5'd0, 3'b000, 5'd18, c_LOAD));    // lb (NOP)
    endtask

    task automatic test_reset();
        logic [31:0] v;
        load_program();
        #2 rest = 1'b0;
        #10;
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", v); end
        for (int i = 1; i < 32; i++) begin
            v = dut.u_cpu_core.u_regs.x_regs[i];
            n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_x%0d: got %h want 00000000", i, v); end
        end
        @(negedge clk);
        rest = 1'b1;
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL release_pc: got %h want 00000000", v); end
    endtask

    task automatic test_alu();
        logic [31:0] exp_x [0:3];
        int          rd_of [0:3];
        logic [31:0] v;
        exp_x = '{32'd5, 32'd3, 32'd8, 32'hFFFF_FFFE};
        rd_of = '{1, 3, 4, 5};
        for (int k = 0; k < 4; k++) begin
            step(1);
            v = dut.u_cpu_core.u_regs.x_regs[rd_of[k]];
            n_checks++; if (v !== exp_x[k]) begin n_fail++; $display("FAIL alu_x%0d: got %h want %h", rd_of[k], v, exp_x[k]); end
            v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
            n_checks++; if (v !== 32'(4 * (k + 1))) begin n_fail++; $display("FAIL alu_pc%0d: got %h want %h", k, v, 4 * (k + 1)); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [0:2];
        logic [31:0] v;
        exp_pc = '{32'h18, 32'h1C, 32'h20};   // beq taken, bne not, bltu not
        for (int k = 0; k < 3; k++) begin
            step(1);
            v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
            n_checks++; if (v !== exp_pc[k]) begin n_fail++; $display("FAIL branch_pc%0d: got %h want %h", k, v, exp_pc[k]); end
        end
    endtask

    task automatic test_jumps();
        logic [31:0] v;
        step(1);
        v = dut.u_cpu_core.u_regs.x_regs[1];
        n_checks++; if (v !== 32'h24) begin n_fail++; $display("FAIL jal_link: got %h want 00000024", v); end
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h2C) begin n_fail++; $display("FAIL jal_pc: got %h want 0000002c", v); end
        step(1);
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h24) begin n_fail++; $display("FAIL jalr_pc: got %h want 00000024", v); end
        step(1);
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h30) begin n_fail++; $display("FAIL blt_pc: got %h want 00000030", v); end
        v = dut.u_cpu_core.u_regs.x_regs[9];
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL skipped_x9: got %h want 00000000", v); end
    endtask

    task automatic test_x0_lui_shift();
        logic [31:0] v;
        step(3);
        v = dut.u_cpu_core.u_regs.x_regs[0];
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL x0_zero: got %h want 00000000", v); end
        v = dut.u_cpu_core.u_regs.x_regs[6];
        n_checks++; if (v !== 32'h1234_5000) begin n_fail++; $display("FAIL lui_x6: got %h want 12345000", v); end
        v = dut.u_cpu_core.u_regs.x_regs[7];
        n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL srai_x7: got %h want ffffffff", v); end
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h3C) begin n_fail++; $display("FAIL shift_pc: got %h want 0000003c", v); end
    endtask

    task automatic test_memory();
        logic [31:0] v;
        step(2);
        v = dut.u_cpu_core.u_regs.x_regs[6];
        n_checks++; if (v !== 32'd8) begin n_fail++; $display("FAIL lw_x6: got %h want 00000008", v); end
    endtask

    task automatic test_alu_more();
        logic [31:0] exp_x [0:5];
        logic [31:0] v;
        exp_x = '{32'h1044, 32'h40, 32'h1FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0};
        step(6);
        for (int k = 0; k < 6; k++) begin
            v = dut.u_cpu_core.u_regs.x_regs[10 + k];
            n_checks++; if (v !== exp_x[k]) begin n_fail++; $display("FAIL alu2_x%0d: got %h want %h", 10 + k, v, exp_x[k]); end
        end
        step(1);
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h60) begin n_fail++; $display("FAIL ecall_pc: got %h want 00000060", v); end
        step(1);
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h68) begin n_fail++; $display("FAIL bgeu_pc: got %h want 00000068", v); end
        step(3);
        v = dut.u_cpu_core.u_regs.x_regs[16];
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL sltiu_x16: got %h want 00000001", v); end
        v = dut.u_cpu_core.u_regs.x_regs[17];
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL xori_x17: got %h want 00000001", v); end
        v = dut.u_cpu_core.u_regs.x_regs[18];
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL lb_nop_x18: got %h want 00000000", v); end
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h74) begin n_fail++; $display("FAIL nop_pc: got %h want 00000074", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        put(32'h00, enc_i(12'd4, 5'd0, 3'b010, 5'd6, c_LOAD));       // lw x6,4(x0)
        #2 rest = 1'b0;
        #1;
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_reset_pc: got %h want 00000000", v); end
        v = dut.u_cpu_core.u_regs.x_regs[6];
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_reset_x6: got %h want 00000000", v); end
        v = dut.u_cpu_core.u_regs.x_regs[17];
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_reset_x17: got %h want 00000000", v); end
        @(negedge clk);
        rest = 1'b1;
        step(1);
        v = dut.u_cpu_core.u_regs.x_regs[6];
        n_checks++; if (v !== 32'd8) begin n_fail++; $display("FAIL ram_retained: got %h want 00000008", v); end
        v = dut.u_cpu_core.u_pc_reg.pc2if_addr_o;
        n_checks++; if (v !== 32'h4) begin n_fail++; $display("FAIL restart_pc: got %h want 00000004", v); end
        step(1);
        v = dut.u_cpu_core.u_regs.x_regs[3];
        n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL restart_x3: got %h want fffffffe", v); end
    endtask

    initial begin
        rest     = 1'b1;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu();
        test_branch();
        test_jumps();
        test_x0_lui_shift();
        test_memory();
        test_alu_more();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
